// File: rtl/debug_frame_serializer.sv
// debug_frame_serializer
//   Walks PC, pipeline-latch words, register file and data memory on one
//   start pulse and streams every LEN-bit word to the UART transmitter as
//   LEN_DATA-bit bytes, MSB first, over a tx_start/tx_done handshake.
//   Section order: PC (1 word), latches (NB_LATCHES), regs (CANT_REGS),
//   data memory (CANT_MEM).
//
// Optional feature: define DEBUG_FRAME_SERIALIZER_CHECKSUM_EN to append one
//   trailing byte holding the XOR of every data byte of the frame.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start           begin a frame (accepted only when idle)
//   abort           drop the current frame and return to idle
//   pc              current PC word
//   latch_data      NB_LATCHES words, word k at [k*LEN +: LEN]
//   regs, mem_datos register-file / data-memory read data for addr
//   addr            read index for regs/mem ports
//   tx_done         UART byte-sent pulse
//   tx_start        one-cycle pulse, uart_data_out valid
//   uart_data_out   byte to transmit (held until the next byte)
//   busy            high from start accept until the frame ends
//   frame_done      one-cycle pulse after the last byte's tx_done
module debug_frame_serializer #(
  parameter int LEN        = 32,
  parameter int LEN_DATA   = 8,
  parameter int NB_LATCHES = 4,
  parameter int CANT_REGS  = 32,
  parameter int CANT_MEM   = 16,
  parameter int ADDR_W     =
    ((((CANT_REGS > CANT_MEM) ? CANT_REGS : CANT_MEM) > NB_LATCHES)
       ? ((CANT_REGS > CANT_MEM) ? CANT_REGS : CANT_MEM) : NB_LATCHES) > 1
    ? $clog2((((CANT_REGS > CANT_MEM) ? CANT_REGS : CANT_MEM) > NB_LATCHES)
       ? ((CANT_REGS > CANT_MEM) ? CANT_REGS : CANT_MEM) : NB_LATCHES)
    : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [LEN-1:0]             pc,
  input  logic [NB_LATCHES*LEN-1:0]  latch_data,
  input  logic [LEN-1:0]             regs,
  input  logic [LEN-1:0]             mem_datos,
  output logic [ADDR_W-1:0]          addr,
  input  logic                       tx_done,
  output logic                       tx_start,
  output logic [LEN_DATA-1:0]        uart_data_out,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int BPW = LEN / LEN_DATA;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX,
    S_NEXT,
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
    S_CHK,
    S_CHK_WAIT,
`endif
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_LATCH,
    SEC_REGS,
    SEC_MEM
  } sec_t;

  state_t              state_q;
  sec_t                sec_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [BCW-1:0]      byte_cnt_q;
  logic [LEN-1:0]      shift_q;
  logic                tx_start_q;
  logic [LEN_DATA-1:0] uart_q;
  logic                busy_q;
  logic                frame_done_q;
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
  logic [LEN_DATA-1:0] acc_q;
`endif

  logic [LEN-1:0]      word_d;
  logic [LEN-1:0]      shifted_d;
  logic [ADDR_W-1:0]   sec_last_d;

  // Source word for the current section/index, plus the last index of that section.
  always_comb begin
    word_d     = pc;
    sec_last_d = '0;
    case (sec_q)
      SEC_PC: begin
        word_d     = pc;
        sec_last_d = '0;
      end
      SEC_LATCH: begin
        word_d = latch_data[LEN-1:0];
        for (int unsigned k = 0; k < NB_LATCHES; k++) begin
          if (idx_q == ADDR_W'(k)) word_d = latch_data[k*LEN +: LEN];
        end
        sec_last_d = ADDR_W'(NB_LATCHES - 1);
      end
      SEC_REGS: begin
        word_d     = regs;
        sec_last_d = ADDR_W'(CANT_REGS - 1);
      end
      SEC_MEM: begin
        word_d     = mem_datos;
        sec_last_d = ADDR_W'(CANT_MEM - 1);
      end
      default: begin
        word_d     = pc;
        sec_last_d = '0;
      end
    endcase
  end

  assign shifted_d = shift_q << LEN_DATA;

  // Read index is only presented while the word is being fetched.
  assign addr = (((state_q == S_LOAD) || (state_q == S_CAPTURE)) &&
                 ((sec_q == SEC_REGS) || (sec_q == SEC_MEM))) ? idx_q : '0;

  assign tx_start      = tx_start_q;
  assign uart_data_out = uart_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

  // tx_start/uart_data_out are loaded on the transition into SEND so the
  // pulse coincides with the SEND cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sec_q        <= SEC_PC;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      tx_start_q   <= 1'b0;
      uart_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
      acc_q        <= '0;
`endif
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        sec_q      <= SEC_PC;
        idx_q      <= '0;
        byte_cnt_q <= '0;
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
        acc_q      <= '0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q    <= S_LOAD;
              busy_q     <= 1'b1;
              sec_q      <= SEC_PC;
              idx_q      <= '0;
              byte_cnt_q <= '0;
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
              acc_q      <= '0;
`endif
            end
          end
          S_LOAD: state_q <= S_CAPTURE;
          S_CAPTURE: begin
            shift_q    <= word_d;
            byte_cnt_q <= '0;
            uart_q     <= word_d[LEN-1 -: LEN_DATA];
            tx_start_q <= 1'b1;
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
            acc_q      <= acc_q ^ word_d[LEN-1 -: LEN_DATA];
`endif
            state_q    <= S_SEND;
          end
          S_SEND: state_q <= S_WAIT_TX;
          S_WAIT_TX: begin
            if (tx_done) begin
              if (byte_cnt_q != BCW'(BPW - 1)) begin
                shift_q    <= shifted_d;
                byte_cnt_q <= byte_cnt_q + BCW'(1);
                uart_q     <= shifted_d[LEN-1 -: LEN_DATA];
                tx_start_q <= 1'b1;
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
                acc_q      <= acc_q ^ shifted_d[LEN-1 -: LEN_DATA];
`endif
                state_q    <= S_SEND;
              end else begin
                state_q <= S_NEXT;
              end
            end
          end
          S_NEXT: begin
            if (idx_q != sec_last_d) begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= S_LOAD;
            end else begin
              idx_q <= '0;
              if (sec_q == SEC_MEM) begin
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
                uart_q     <= acc_q;
                tx_start_q <= 1'b1;
                state_q    <= S_CHK;
`else
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= S_DONE;
`endif
              end else begin
                sec_q   <= sec_t'(sec_q + 2'd1);
                state_q <= S_LOAD;
              end
            end
          end
`ifdef DEBUG_FRAME_SERIALIZER_CHECKSUM_EN
          S_CHK: state_q <= S_CHK_WAIT;
          S_CHK_WAIT: begin
            if (tx_done) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= S_DONE;
            end
          end
`endif
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
